// File: rtl/fft16_input_loader.sv
// Ping-pong frame loader feeding the first radix-4 stage: 16 streamed samples out as one 4x4-lane beat.
// Optional start-of-frame resync (partial frame discarded, drop_o pulsed) under `FFT16_LOADER_SOF_EN.
module fft16_input_loader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rst_i,
  input  logic [DATA_WIDTH-1:0]     din_real_i,
  input  logic [DATA_WIDTH-1:0]     din_imag_i,
  input  logic                      din_valid_i,
  input  logic                      din_sof_i,
  output logic                      din_ready_o,
  output logic [DATA_WIDTH*4-1:0]   xn1_real_o,
  output logic [DATA_WIDTH*4-1:0]   xn2_real_o,
  output logic [DATA_WIDTH*4-1:0]   xn3_real_o,
  output logic [DATA_WIDTH*4-1:0]   xn4_real_o,
  output logic [DATA_WIDTH*4-1:0]   xn1_imag_o,
  output logic [DATA_WIDTH*4-1:0]   xn2_imag_o,
  output logic [DATA_WIDTH*4-1:0]   xn3_imag_o,
  output logic [DATA_WIDTH*4-1:0]   xn4_imag_o,
  output logic                      frame_valid_o,
  input  logic                      frame_ready_i,
  output logic                      drop_o
);

  logic [DATA_WIDTH-1:0] re_q [2][16];
  logic [DATA_WIDTH-1:0] im_q [2][16];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [3:0]            wr_idx_q, wr_idx_d;
  logic                  accept, consume;
  logic [3:0]            wr_addr;
  logic [DATA_WIDTH*4-1:0] re_grp [4];
  logic [DATA_WIDTH*4-1:0] im_grp [4];

  // Handshake outputs depend on registered state only.
  assign din_ready_o   = !full_q[wr_bank_q];
  assign frame_valid_o = full_q[rd_bank_q];
  assign accept        = din_valid_i && din_ready_o;
  assign consume       = frame_valid_o && frame_ready_i;

`ifdef FFT16_LOADER_SOF_EN
  logic drop_q, drop_d;
  assign wr_addr = (accept && din_sof_i) ? 4'd0 : wr_idx_q;
  assign drop_d  = accept && din_sof_i && (wr_idx_q != 4'd0);
  assign drop_o  = drop_q;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end
`else
  logic unused_sof;
  assign unused_sof = din_sof_i;
  assign wr_addr    = wr_idx_q;
  assign drop_o     = 1'b0;
`endif

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    if (accept) begin
      wr_idx_d = wr_addr + 4'd1;
      if (wr_addr == 4'd15) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // A completing write targets an empty bank, a consume a full one, so both may apply.
    if (consume) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= 4'd0;
      re_q      <= '{default: '0};
      im_q      <= '{default: '0};
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      if (accept) begin
        re_q[wr_bank_q][wr_addr] <= din_real_i;
        im_q[wr_bank_q][wr_addr] <= din_imag_i;
      end
    end
  end

  // Lane i of group g carries x[4g+i]; forced to zero when no frame is presented.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      re_grp[g] = '0;
      im_grp[g] = '0;
      for (int i = 0; i < 4; i++) begin
        if (frame_valid_o) begin
          re_grp[g][DATA_WIDTH*i +: DATA_WIDTH] = re_q[rd_bank_q][4'(4*g+i)];
          im_grp[g][DATA_WIDTH*i +: DATA_WIDTH] = im_q[rd_bank_q][4'(4*g+i)];
        end
      end
    end
  end

  assign xn1_real_o = re_grp[0];
  assign xn2_real_o = re_grp[1];
  assign xn3_real_o = re_grp[2];
  assign xn4_real_o = re_grp[3];
  assign xn1_imag_o = im_grp[0];
  assign xn2_imag_o = im_grp[1];
  assign xn3_imag_o = im_grp[2];
  assign xn4_imag_o = im_grp[3];

endmodule

// File: tb/tb_fft16_input_loader.sv
// Scoreboard bench for fft16_input_loader: expected frames queued on stimulus, checked by a monitor on consume.
`timescale 1ns/1ps
module tb_fft16_input_loader;
  localparam int DW = 32;
`ifdef FFT16_LOADER_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_real = '0, din_imag = '0;
  logic          din_valid = 1'b0, din_sof = 1'b0, frame_ready = 1'b0;
  logic          din_ready, frame_valid, drop;
  logic [4*DW-1:0] xn1_re, xn2_re, xn3_re, xn4_re, xn1_im, xn2_im, xn3_im, xn4_im;

  fft16_input_loader #(.DATA_WIDTH(DW)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .din_real_i(din_real), .din_imag_i(din_imag),
    .din_valid_i(din_valid), .din_sof_i(din_sof), .din_ready_o(din_ready),
    .xn1_real_o(xn1_re), .xn2_real_o(xn2_re), .xn3_real_o(xn3_re), .xn4_real_o(xn4_re),
    .xn1_imag_o(xn1_im), .xn2_imag_o(xn2_im), .xn3_imag_o(xn3_im), .xn4_imag_o(xn4_im),
    .frame_valid_o(frame_valid), .frame_ready_i(frame_ready), .drop_o(drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [16*DW-1:0] re;
    logic [16*DW-1:0] im;
  } frame_t;

  frame_t exp_q[$];
  frame_t mon_e;
  int checks = 0, errors = 0;
  int drops_seen = 0, stalls = 0, cyc = 0;
  int consume_cyc[$];
  logic [16*DW-1:0] m_re = '0, m_im = '0;
  int m_idx = 0;

  function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the whole presented frame each time it is consumed.
  always @(negedge clk) begin
    if (!rst) begin
      if (drop) drops_seen++;
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame got=valid expected=none");
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_re", {xn4_re, xn3_re, xn2_re, xn1_re}, mon_e.re);
          chk("frame_im", {xn4_im, xn3_im, xn2_im, xn1_im}, mon_e.im);
          consume_cyc.push_back(cyc);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the sample.
  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic sof);
    int w = 0;
    din_real = re; din_imag = im; din_sof = sof; din_valid = 1'b1;
    while (!din_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=ready0 expected=ready1");
      din_valid = 1'b0;
      return;
    end
    stalls += w;
    @(posedge clk); #1;
    din_valid = 1'b0; din_sof = 1'b0;
    if (SOF_EN && sof) m_idx = 0;
    m_re[m_idx*DW +: DW] = re;
    m_im[m_idx*DW +: DW] = im;
    m_idx++;
    if (m_idx == 16) begin
      exp_q.push_back({m_re, m_im});
      m_idx = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    // Reset state
    @(posedge clk); #1;
    chk("rst_ready", din_ready, 1);
    chk("rst_valid", frame_valid, 0);
    chk("rst_drop", drop, 0);
    chk("rst_xn1_re", xn1_re, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single frame
    frame_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send(32'(n), 32'(-n), 1'b0);
      if (n == 14) chk("t1_valid_early", frame_valid, 0);
    end
    chk("t1_valid", frame_valid, 1);
    chk("t1_xn1_re", xn1_re, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t1_xn4_re_l3", xn4_re[127:96], 32'd15);
    chk("t1_xn2_im_l0", xn2_im[31:0], 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("t1_valid_once", frame_valid, 0);

    // Backpressure
    frame_ready = 1'b0;
    for (int n = 0; n < 32; n++) send(32'(1000 + n), 32'(2000 + n), 1'b0);
    chk("t2_ready_low", din_ready, 0);
    chk("t2_valid", frame_valid, 1);
    chk("t2_f0_xn1_re", xn1_re, {32'd1003, 32'd1002, 32'd1001, 32'd1000});
    din_real = 32'd1032; din_imag = 32'd2032; din_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t2_ready_held", din_ready, 0);
    chk("t2_f0_stable_re", xn1_re, {32'd1003, 32'd1002, 32'd1001, 32'd1000});
    chk("t2_f0_stable_im", xn4_im, {32'd2015, 32'd2014, 32'd2013, 32'd2012});
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
    chk("t2_f1_valid", frame_valid, 1);
    chk("t2_ready_rise", din_ready, 1);
    chk("t2_f1_xn1_re", xn1_re, {32'd1019, 32'd1018, 32'd1017, 32'd1016});
    for (int n = 32; n < 48; n++) send(32'(1000 + n), 32'(2000 + n), 1'b0);
    frame_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t2_drained", exp_q.size(), 0);

    // Back-to-back
    stalls = 0;
    consume_cyc.delete();
    for (int n = 0; n < 64; n++) send(32'(3000 + n), 32'(4000 + n), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_stalls", stalls, 0);
    chk("t3_frames", consume_cyc.size(), 4);
    if (consume_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("t3_interval", consume_cyc[k] - consume_cyc[k-1], 16);

    // SOF resync
    drops_seen = 0;
    for (int n = 0; n < 5; n++) send(32'(n), 32'(-n), 1'b0);
    send(32'd100, 32'(-100), 1'b1);
    chk("t4_drop_pulse", drop, SOF_EN);
    found = 0;
    for (int n = 1; n < 16; n++) begin
      send(32'(200 + n), 32'(-200 - n), 1'b0);
      if (frame_valid) begin
        chk("t4_lane0", xn1_re[31:0], SOF_EN ? 32'd100 : 32'd0);
        found++;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("t4_frame_seen", found, 1);
    chk("t4_drop_count", drops_seen, SOF_EN ? 1 : 0);

    // Async reset mid-frame with a frame pending
    do_reset();
    frame_ready = 1'b0;
    for (int n = 0; n < 23; n++) send(32'(600 + n), 32'(700 + n), 1'b0);
    chk("t5_pending", frame_valid, 1);
    #3 rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    #1;
    chk("t5_rst_valid", frame_valid, 0);
    chk("t5_rst_ready", din_ready, 1);
    chk("t5_rst_drop", drop, 0);
    chk("t5_rst_xn1_re", xn1_re, 0);
    chk("t5_rst_xn3_im", xn3_im, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    frame_ready = 1'b1;
    for (int n = 0; n < 16; n++) send(32'(5000 + n), 32'(-5000 - n), 1'b0);
    chk("t5_xn1_re", xn1_re, {32'd5003, 32'd5002, 32'd5001, 32'd5000});
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft16_input_loader.md
# fft16_input_loader

Input stage for the 16-point radix-4 FFT datapath. It accepts one complex sample per cycle over a valid/ready stream and assembles each 16-sample frame in a ping-pong buffer. It presents a completed frame in one beat, in the packed four-lane layout the first radix-4 butterfly stage consumes: lane i of group g carries x[4g+i]. The butterfly therefore combines x[i], x[i+4], x[i+8] and x[i+12] in lane i.

## Interface
- DATA_WIDTH, 32, signed sample width of the real and imaginary parts.
- sys_clk_i  in  1  single clock; all logic on the rising edge.
- sys_rst_i  in  1  reset, asynchronous, active-high.
- din_real_i  in  DATA_WIDTH  signed real part of the input sample.
- din_imag_i  in  DATA_WIDTH  signed imaginary part of the input sample.
- din_valid_i  in  1  input sample valid.
- din_sof_i  in  1  start-of-frame marker; used only when FFT16_LOADER_SOF_EN is defined.
- din_ready_o  out  1  loader can accept a sample.
- xn1_real_o … xn4_real_o  out  DATA_WIDTH*4  each a signed group; xnG lane i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i] and carries x[4(G-1)+i].
- xn1_imag_o … xn4_imag_o  out  DATA_WIDTH*4  imaginary parts, packed in the same layout.
- frame_valid_o  out  1  a complete frame is presented.
- frame_ready_i  in  1  downstream consumes the frame.
- drop_o  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Storage: two banks of 16 complex entries each, plus per-bank full flags, a write-bank pointer, a read-bank pointer and a 4-bit write index.
- Accept condition: din_valid_i && din_ready_o.
  - On accept, the sample is stored at [wr_bank][wr_idx] and wr_idx increments.
  - When the accept writes index 15, full[wr_bank] is set, wr_bank toggles and wr_idx wraps to 0.
- din_ready_o = !full[wr_bank]. It is a function of registered state only; there is no combinational path from frame_ready_i or din_valid_i.
- frame_valid_o = full[rd_bank].
  - Data outputs show bank rd_bank while frame_valid_o is high.
  - All data outputs are 0 while frame_valid_o is low.
- Consume condition: frame_valid_o && frame_ready_i.
  - On consume, full[rd_bank] is cleared and rd_bank toggles.
- Simultaneous events:
  - A consume and a bank-completing write in the same cycle both take effect, and they act on different banks.
  - A consume frees a bank, but din_ready_o rises only in the following cycle.
- Presented data stays stable while frame_valid_o is high and frame_ready_i is low.
- No arithmetic and no width growth: samples pass through bit-exact.
- Reset:
  - Clears both full flags, both pointers, wr_idx, drop_o and all storage.
  - All outputs are 0, except din_ready_o, which is 1.
  - Reset takes effect immediately, mid-frame included; any partial frame and any pending frames are lost.

## Timing
- Latency: the frame whose 16th sample is accepted at edge t is presented with frame_valid_o = 1 after edge t (visible in cycle t+1).
- Throughput: one sample per cycle, sustained, provided each frame is consumed within 16 cycles of presentation.
- Backpressure: with frame_ready_i held low, the loader accepts exactly 32 samples, then drops din_ready_o.
- drop_o is registered: it is high for the single cycle after the discarding accept.

## Configuration
- FFT16_LOADER_SOF_EN defined:
  - An accept with din_sof_i = 1 writes the sample at index 0 of the current write bank and sets wr_idx to 1.
  - If wr_idx was nonzero at that accept, the partial frame is discarded and drop_o pulses.
  - If wr_idx was already 0, the accept is a normal write and drop_o stays 0.
- FFT16_LOADER_SOF_EN undefined: din_sof_i is ignored and drop_o is tied to 0.

## Test plan
- Single frame: reset, then stream n = 0..15 with real = n, imag = -n, and frame_ready_i = 1.
  - frame_valid_o is high for exactly one cycle, in the cycle after the 16th accept.
  - xn1_real_o lanes = 0,1,2,3; xn4_real_o lane 3 = 15; xn2_imag_o lane 0 = -4.
- Backpressure: hold frame_ready_i = 0 and stream 40 samples continuously.
  - din_ready_o falls after the 32nd accept.
  - Frame 0 is held stable.
  - Pulse frame_ready_i for one cycle: frame 1 appears in the next cycle, and din_ready_o rises in that same cycle.
- Back-to-back: stream 64 samples with frame_ready_i = 1.
  - frame_valid_o pulses every 16 cycles.
  - din_ready_o never drops.
- SOF resync (macro on): 5 samples, then sof with real = 100, then 15 samples.
  - drop_o pulses once.
  - The frame presents xn1_real_o lane 0 = 100.
  - With the macro off, the same stimulus gives no drop_o pulse and lane 0 = 0.
- Async reset: assert sys_rst_i mid-frame after 7 samples, asynchronously to the clock.
  - All outputs go to 0 immediately (din_ready_o = 1).
  - The next 16 samples form a correct frame.
